// File: rtl/hit_circular_buffer_mc_if.sv
// Hit-buffer bus: per-channel hit input, L1A request/latency and registered readout.
// master drives hits and L1A; slave is the buffer.
interface hit_circular_buffer_mc_if #(
    parameter int unsigned NCH   = 1,
    parameter int unsigned DEPTH = 512
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NCH-1:0] hit;
    logic           L1A;
    logic [AW-1:0]  latency;
    logic [AW-1:0]  wrAddr;
    logic [NCH-1:0] outHit;
    logic           outValid;
    logic           latencyErr;

    modport master (
        output hit, L1A, latency,
        input  wrAddr, outHit, outValid, latencyErr
    );

    modport slave (
        input  hit, L1A, latency,
        output wrAddr, outHit, outValid, latencyErr
    );
endinterface

// File: rtl/hit_circular_buffer_mc.sv
// Multi-channel hit circular buffer: hits packed WORD_W per row, staging-register bypass for the
// row still being filled, and fill gating so reads of never-written slots return zero.
module hit_circular_buffer_mc #(
    parameter int unsigned NCH    = 1,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned WORD_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    hit_circular_buffer_mc_if.slave  bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned WB   = $clog2(WORD_W);
    localparam int unsigned RW   = AW - WB;
    localparam int unsigned ROWS = DEPTH / WORD_W;

    typedef logic [NCH-1:0][WORD_W-1:0] row_t;

    row_t           mem [ROWS];
    row_t           stage;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  fill_cnt;
    logic [NCH-1:0] out_hit;
    logic           out_valid;
    logic           latency_err;

    logic [RW-1:0]  wr_row;
    logic [WB-1:0]  wr_bit;
    logic [AW-1:0]  rd_addr_c;
    logic [RW-1:0]  rd_row_c;
    logic [WB-1:0]  rd_bit_c;
    logic           use_stage_c;
    row_t           rd_word_c;
    logic [NCH-1:0] rd_hit_c;
    row_t           commit_row_c;
    logic           lat_zero_c;
    logic           unfilled_c;

    assign wr_row = wr_addr[AW-1:WB];
    assign wr_bit = wr_addr[WB-1:0];

    // Read-address decode and staging/memory source select; the row under construction lives in stage.
    always_comb begin
        rd_addr_c    = wr_addr - bus.latency;
        rd_row_c     = rd_addr_c[AW-1:WB];
        rd_bit_c     = rd_addr_c[WB-1:0];
        use_stage_c  = (rd_row_c == wr_row) && (rd_bit_c < wr_bit);
        rd_word_c    = use_stage_c ? stage : mem[rd_row_c];
        lat_zero_c   = (bus.latency == '0);
        unfilled_c   = (bus.latency > fill_cnt);
        rd_hit_c     = '0;
        commit_row_c = stage;
        for (int unsigned c = 0; c < NCH; c++) begin
            rd_hit_c[c]                = rd_word_c[c][rd_bit_c];
            commit_row_c[c][WORD_W-1]  = bus.hit[c];
        end
    end

    // Write pointer, fill tracking, staging and registered readout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr     <= '0;
            fill_cnt    <= '0;
            stage       <= '0;
            out_hit     <= '0;
            out_valid   <= 1'b0;
            latency_err <= 1'b0;
        end else begin
            wr_addr <= wr_addr + AW'(1);
            if (fill_cnt != AW'(DEPTH - 1)) begin
                fill_cnt <= fill_cnt + AW'(1);
            end
            if (wr_bit != WB'(WORD_W - 1)) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    stage[c][wr_bit] <= bus.hit[c];
                end
            end
            out_valid   <= bus.L1A;
            latency_err <= bus.L1A && lat_zero_c;
            if (bus.L1A) begin
                if (lat_zero_c || unfilled_c) begin
                    out_hit <= '0;
                end else begin
                    out_hit <= rd_hit_c;
                end
            end
        end
    end

    // Row commit on the last bit of each row; the array is intentionally left uninitialised.
    always_ff @(posedge clk) begin
        if (wr_bit == WB'(WORD_W - 1)) begin
            mem[wr_row] <= commit_row_c;
        end
    end

    assign bus.wrAddr     = wr_addr;
    assign bus.outHit     = out_hit;
    assign bus.outValid   = out_valid;
    assign bus.latencyErr = latency_err;
endmodule

// File: tb/tb_hit_circular_buffer_mc.sv
// Directed and scoreboard checks for hit_circular_buffer_mc (4 channels, depth 512, 8 bits per row).
`timescale 1ns/1ps
module tb_hit_circular_buffer_mc;
    localparam int unsigned NCH    = 4;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned WORD_W = 8;
    localparam int unsigned AW     = 9;

    logic clk;
    logic reset;

    hit_circular_buffer_mc_if #(.NCH(NCH), .DEPTH(DEPTH)) bus ();

    hit_circular_buffer_mc #(.NCH(NCH), .DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference history: hit applied at each slot, plus edges seen since the last reset.
    logic [NCH-1:0] hist [DEPTH];
    logic [AW-1:0]  m_wr;
    int             m_edges;
    logic [NCH-1:0] m_hit;

    logic           t_l1a;
    logic [AW-1:0]  t_lat;
    logic [NCH-1:0] t_exp;
    logic [NCH-1:0] t_hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, update the reference, check all outputs.
    task automatic cycle(input logic [NCH-1:0] h, input logic l1a, input logic [AW-1:0] lat);
        logic e_err;
        bus.hit     = h;
        bus.L1A     = l1a;
        bus.latency = lat;
        @(posedge clk);
        e_err = l1a && (lat == '0);
        if (l1a) begin
            if (lat == '0 || int'(lat) > m_edges) m_hit = '0;
            else                                  m_hit = hist[m_wr - lat];
        end
        hist[m_wr] = h;
        m_wr       = m_wr + AW'(1);
        m_edges++;
        #1;
        check("outValid",   32'(bus.outValid),   32'(l1a));
        check("latencyErr", 32'(bus.latencyErr), 32'(e_err));
        check("outHit",     32'(bus.outHit),     32'(m_hit));
        check("wrAddr",     32'(bus.wrAddr),     32'(m_wr));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_outHit",     32'(bus.outHit),     32'(0));
        check("rst_outValid",   32'(bus.outValid),   32'(0));
        check("rst_latencyErr", 32'(bus.latencyErr), 32'(0));
        check("rst_wrAddr",     32'(bus.wrAddr),     32'(0));
        m_wr    = '0;
        m_edges = 0;
        m_hit   = '0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        m_wr    = '0;
        m_edges = 0;
        m_hit   = '0;
        for (int i = 0; i < int'(DEPTH); i++) hist[i] = '0;
        reset       = 1'b0;
        bus.hit     = '0;
        bus.L1A     = 1'b0;
        bus.latency = '0;
        #8;
        check("init_outHit",   32'(bus.outHit),   32'(0));
        check("init_outValid", 32'(bus.outValid), 32'(0));
        check("init_wrAddr",   32'(bus.wrAddr),   32'(0));
        reset = 1'b1;

        // Single hit at edge 5, retrieved at several latencies.
        for (int e = 1; e <= 210; e++) begin
            t_l1a = 1'b1;
            t_lat = '0;
            t_exp = '0;
            case (e)
                6:       begin t_lat = 9'd1;   t_exp = 4'b0001; end
                12:      begin t_lat = 9'd7;   t_exp = 4'b0001; end
                13:      begin t_lat = 9'd8;   t_exp = 4'b0001; end
                14:      begin t_lat = 9'd9;   t_exp = 4'b0001; end
                205:     begin t_lat = 9'd200; t_exp = 4'b0001; end
                10:      begin t_lat = 9'd4;   t_exp = 4'b0000; end
                100:     begin t_lat = 9'd50;  t_exp = 4'b0000; end
                206:     begin t_lat = 9'd200; t_exp = 4'b0000; end
                default: t_l1a = 1'b0;
            endcase
            cycle((e == 5) ? 4'b0001 : 4'b0000, t_l1a, t_lat);
            if (t_l1a) check("single_hit", 32'(bus.outHit), 32'(t_exp));
        end
        check("wrAddr_210", 32'(bus.wrAddr), 32'(210));

        // Staging bypass around a row boundary: hit at slot 16.
        do_reset();
        for (int w = 0; w <= 30; w++) begin
            t_l1a = (w >= 17 && w <= 26);
            t_lat = (w >= 25) ? 9'd9 : AW'(w - 16);
            t_exp = (w >= 17 && w <= 25) ? 4'b0001 : 4'b0000;
            cycle((w == 16) ? 4'b0001 : 4'b0000, t_l1a, t_lat);
            if (t_l1a) check("bypass", 32'(bus.outHit), 32'(t_exp));
        end

        // latency 0 is flagged for one clock only.
        cycle(4'b0000, 1'b1, 9'd0);
        check("lat0_err",   32'(bus.latencyErr), 32'(1));
        check("lat0_valid", 32'(bus.outValid),   32'(1));
        check("lat0_hit",   32'(bus.outHit),     32'(0));
        cycle(4'b0000, 1'b0, 9'd5);
        check("lat0_err_clr", 32'(bus.latencyErr), 32'(0));

        // Fill gating against stale all-ones memory.
        for (int i = 0; i < 600; i++) cycle(4'b1111, 1'b0, 9'd0);
        do_reset();
        cycle(4'b1010, 1'b0, 9'd0);
        cycle(4'b0000, 1'b0, 9'd0);
        cycle(4'b0000, 1'b1, 9'd10);
        check("fill_hit",   32'(bus.outHit),     32'(0));
        check("fill_err",   32'(bus.latencyErr), 32'(0));
        check("fill_valid", 32'(bus.outValid),   32'(1));
        cycle(4'b0000, 1'b1, 9'd3);
        check("fill_edge_ok", 32'(bus.outHit), 32'(4'b1010));
        cycle(4'b0000, 1'b1, 9'd5);
        check("fill_edge_gated", 32'(bus.outHit), 32'(0));

        // Wrap with maximum latency and random hits.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            t_hit = 4'($urandom());
            cycle(t_hit, 1'b1, 9'd511);
        end

        // Random per-channel hits and latencies, back-to-back L1A, reset mid-run.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                check("pre_reset_valid", 32'(bus.outValid), 32'(1));
                do_reset();
            end
            t_hit = 4'($urandom());
            t_lat = 9'($urandom_range(0, 511));
            cycle(t_hit, 1'b1, t_lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
